// File: rtl/v_alu_pkg.sv
// Shared definitions for the v_alu SIMD vector ALU: op encodings, SEW codes and the VLEN width.
package v_alu_pkg;

  localparam int VLEN = 128;

  typedef enum logic [2:0] {
    VADD_VV = 3'b000,
    VSUB_VV = 3'b001,
    VAND    = 3'b010,
    VOR     = 3'b011,
    VXOR    = 3'b100,
    VADD_VX = 3'b101,
    VSLL    = 3'b110,
    VMUL    = 3'b111
  } valu_op_e;

  localparam logic [7:0] SEW8   = 8'd8;
  localparam logic [7:0] SEW16  = 8'd16;
  localparam logic [7:0] SEW32  = 8'd32;
  localparam logic [7:0] SEW64  = 8'd64;
  localparam logic [7:0] SEW128 = 8'd128;

endpackage

// File: rtl/v_alu_lane_op.sv
// One W-bit element lane of the vector ALU; all arithmetic wraps modulo 2^W.
// Optional multiply is enabled by defining V_ALU_MUL_EN.
module v_alu_lane_op
  import v_alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_s,
  input  logic [2:0]   i_op,
  output logic [W-1:0] o_y
);

  localparam int SHW = $clog2(W);

  logic [W-1:0] w_prod;

`ifdef V_ALU_MUL_EN
  assign w_prod = i_a * i_b;
`else
  assign w_prod = '0;
`endif

  // NOTE: o_y gets a default before the case so every path assigns it and no latch is inferred.
  always_comb begin
    o_y = '0;
    case (i_op)
      VADD_VV: o_y = i_a + i_b;
      VSUB_VV: o_y = i_a - i_b;
      VAND:    o_y = i_a & i_b;
      VOR:     o_y = i_a | i_b;
      VXOR:    o_y = i_a ^ i_b;
      VADD_VX: o_y = i_a + i_s;
      VSLL:    o_y = i_a << i_b[SHW-1:0];
      VMUL:    o_y = w_prod;
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/v_alu.sv
// Registered 128-bit SIMD vector ALU: every SEW lane set is computed in parallel, the
// requested width is selected and captured each clock. Multiply is gated by V_ALU_MUL_EN.
module v_alu
  import v_alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [VLEN-1:0]   reg_in1,
  input  logic [VLEN-1:0]   reg_in2,
  input  logic [VLEN-1:0]   reg_scalar_in,
  input  logic [2:0]        valu_op,
  input  logic [7:0]        SEW,
  output logic [VLEN-1:0]   reg_dest
);

  logic [4:0][VLEN-1:0] w_res;
  logic [VLEN-1:0]      w_next;
  logic [VLEN-1:0]      r_dest;

  // Element 0 sits in the most significant slot of each width's result.
  for (genvar k = 0; k < 5; k++) begin : g_sew
    localparam int W = 8 << k;
    localparam int N = VLEN / W;
    for (genvar e = 0; e < N; e++) begin : g_lane
      v_alu_lane_op #(.W(W)) u_lane (
        .i_a  (reg_in1[VLEN-1-e*W -: W]),
        .i_b  (reg_in2[VLEN-1-e*W -: W]),
        .i_s  (reg_scalar_in[W-1:0]),
        .i_op (valu_op),
        .o_y  (w_res[k][VLEN-1-e*W -: W])
      );
    end
  end

  always_comb begin
    w_next = '0;
    case (SEW)
      SEW8:    w_next = w_res[0];
      SEW16:   w_next = w_res[1];
      SEW32:   w_next = w_res[2];
      SEW64:   w_next = w_res[3];
      SEW128:  w_next = w_res[4];
      default: w_next = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_dest <= '0;
    else     r_dest <= w_next;
  end

  assign reg_dest = r_dest;

endmodule

// File: tb/tb_v_alu.sv
// Self-checking bench for v_alu: element-wise reference model plus directed literal vectors.
module tb_v_alu;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] reg_in1, reg_in2, reg_scalar_in;
  logic [2:0]   valu_op;
  logic [7:0]   SEW;
  logic [127:0] reg_dest;

  int total = 0;
  int bad   = 0;

  logic [127:0] m_exp;
  logic         m_valid;

  v_alu dut (
    .clk           (clk),
    .rst           (rst),
    .reg_in1       (reg_in1),
    .reg_in2       (reg_in2),
    .reg_scalar_in (reg_scalar_in),
    .valu_op       (valu_op),
    .SEW           (SEW),
    .reg_dest      (reg_dest)
  );

  always #5 clk = ~clk;

  // Reference: slice each operand into elements, do plain wrapped arithmetic, reassemble.
  function automatic logic [127:0] model(input logic [127:0] a, input logic [127:0] b,
                                         input logic [127:0] s, input logic [2:0] op,
                                         input logic [7:0] sew);
    logic [127:0] r, mask, x, y, z;
    int w, sh;
    r = '0;
    if (!(sew inside {8'd8, 8'd16, 8'd32, 8'd64, 8'd128})) return '0;
    w = int'(sew);
    mask = (w == 128) ? {128{1'b1}} : ((128'd1 << w) - 128'd1);
    for (int e = 0; e < 128 / w; e++) begin
      sh = 128 - (e + 1) * w;
      x = (a >> sh) & mask;
      y = (b >> sh) & mask;
      case (op)
        3'd0: z = x + y;
        3'd1: z = x - y;
        3'd2: z = x & y;
        3'd3: z = x | y;
        3'd4: z = x ^ y;
        3'd5: z = x + (s & mask);
        3'd6: z = x << (y % 128'(w));
`ifdef V_ALU_MUL_EN
        default: z = x * y;
`else
        default: z = '0;
`endif
      endcase
      r = r | ((z & mask) << sh);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_exp   <= '0;
      m_valid <= 1'b0;
    end else begin
      m_exp   <= model(reg_in1, reg_in2, reg_scalar_in, valu_op, SEW);
      m_valid <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst && m_valid) check("model", reg_dest, m_exp);
  end

  task automatic drive(input logic [127:0] a, input logic [127:0] b, input logic [127:0] s,
                       input logic [2:0] op, input logic [7:0] sew);
    reg_in1 = a; reg_in2 = b; reg_scalar_in = s; valu_op = op; SEW = sew;
  endtask

  task automatic apply(input string name, input logic [127:0] a, input logic [127:0] b,
                       input logic [127:0] s, input logic [2:0] op, input logic [7:0] sew,
                       input logic [127:0] exp);
    @(negedge clk);
    drive(a, b, s, op, sew);
    @(posedge clk);
    #1;
    check(name, reg_dest, exp);
  endtask

  localparam logic [127:0] SW_A  = 128'hf840_00AA_8000_0000_4840_00AA_8000_0000;
  localparam logic [127:0] SW_B  = 128'hf448_00D5_0000_0000_4448_00D5_0000_0000;
  localparam logic [127:0] SW_8  = 128'hec88_007f_8000_0000_8c88_007f_8000_0000;
  localparam logic [127:0] SW_W  = 128'hec88_017f_8000_0000_8c88_017f_8000_0000;
  localparam logic [127:0] MUL_A = {8{16'h0102}};
  localparam logic [127:0] MUL_B = {8{16'h0100}};

  initial begin
    logic [7:0] sews [7];
    sews = '{8'd8, 8'd16, 8'd32, 8'd64, 8'd128, 8'd12, 8'd0};
    rst = 1'b1;
    drive(SW_A, SW_B, 128'h1234, 3'd0, 8'd8);
    #1;
    check("reset_hold", reg_dest, 128'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_clocked", reg_dest, 128'h0);
    @(negedge clk);
    rst = 1'b0;

    // Literal vectors pin the model as well as the DUT.
    check("model_pin_sew8", model(SW_A, SW_B, '0, 3'd0, 8'd8), SW_8);
    check("model_pin_sew128", model(SW_A, SW_B, '0, 3'd0, 8'd128), SW_W);

    apply("vadd_sew8",   SW_A, SW_B, '0, 3'd0, 8'd8,   SW_8);
    apply("vadd_sew16",  SW_A, SW_B, '0, 3'd0, 8'd16,  SW_W);
    apply("vadd_sew32",  SW_A, SW_B, '0, 3'd0, 8'd32,  SW_W);
    apply("vadd_sew64",  SW_A, SW_B, '0, 3'd0, 8'd64,  SW_W);
    apply("vadd_sew128", SW_A, SW_B, '0, 3'd0, 8'd128, SW_W);
    apply("vsub_sew8", {16{8'h01}}, {16{8'h02}}, '0, 3'd1, 8'd8, {16{8'hff}});
    apply("vand_sew8", {16{8'haa}}, {16{8'h0f}}, '0, 3'd2, 8'd8, {16{8'h0a}});
    apply("vor_sew32", {16{8'ha0}}, {16{8'h05}}, '0, 3'd3, 8'd32, {16{8'ha5}});
    apply("vxor_sew64", {16{8'hff}}, {16{8'h0f}}, '0, 3'd4, 8'd64, {16{8'hf0}});
    apply("vaddvx_sew16", {8{16'h0001}}, {8{16'h7777}},
          128'hdead_beef_0000_0000_0000_0000_0000_00ff, 3'd5, 8'd16, {8{16'h0100}});
    apply("vsll_sew8", {16{8'h81}}, {16{8'h09}}, '0, 3'd6, 8'd8, {16{8'h02}});
`ifdef V_ALU_MUL_EN
    apply("vmul_sew16", MUL_A, MUL_B, '0, 3'd7, 8'd16, {8{16'h0200}});
`else
    apply("vmul_sew16", MUL_A, MUL_B, '0, 3'd7, 8'd16, 128'h0);
`endif
    apply("illegal_sew_add", SW_A, SW_B, '0, 3'd0, 8'd12, 128'h0);
    apply("illegal_sew_mul", MUL_A, MUL_B, '0, 3'd7, 8'd12, 128'h0);
    apply("after_illegal", {16{8'h01}}, {16{8'h02}}, '0, 3'd1, 8'd8, {16{8'hff}});

    // Mid-stream reset: output clears without a clock, first edge after release captures inputs.
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset", reg_dest, 128'h0);
    @(posedge clk);
    #1 check("reset_stays_zero", reg_dest, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(SW_A, SW_B, '0, 3'd0, 8'd16);
    @(posedge clk);
    #1 check("first_after_reset", reg_dest, SW_W);

    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      drive({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom}, 3'($urandom_range(0, 7)),
            sews[$urandom_range(0, 6)]);
    end

    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
